fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_stage_imem.sv | 28 ++
 rtl/fetch_stage.sv | 102 ++++++++++
 tb/tb_fetch_stage.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: fetch FSM encodings, NOP word and default ROM image.
// Imported by fetch_stage and instruction_memory.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FS_RUN   = 2'd0,
    FS_STALL = 2'd1,
    FS_FLUSH = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Default program image: every word is distinct and encodes its own index.
  function automatic logic [31:0] imem_default_word(input logic [7:0] idx);
    return {8'hA5, idx, 8'h5A, ~idx};
  endfunction

endpackage

// File: rtl/fetch_stage_imem.sv
// instruction_memory: combinational word-addressed ROM, DEPTH words of 32 bits.
// Zero latency; any word index >= DEPTH reads as the NOP word.
module instruction_memory
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic [29:0] word_addr_i,
  output logic [31:0] data_o
);

  localparam int          IDXW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  logic [31:0] rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign rom[g] = imem_default_word(8'(g));
  end

  always_comb begin
    data_o = NOP_INSTR;
    if ({2'b00, word_addr_i} < DEPTH_U) begin
      data_o = rom[word_addr_i[IDXW-1:0]];
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, instruction fetch and IF/ID register with stall/flush FSM.
// Optional FETCH_STALL_COUNT_EN adds a saturating stall_count output.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          INST_MEM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        valid_out,
  output logic [1:0]  fetch_state
`ifdef FETCH_STALL_COUNT_EN
  ,
  output logic [31:0] stall_count
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic [31:0]  inst_q, inst_d;
  logic         valid_q, valid_d;
  logic [31:0]  imem_data;

  instruction_memory #(
    .DEPTH(INST_MEM_DEPTH)
  ) u_imem (
    .word_addr_i(pc_q[31:2]),
    .data_o     (imem_data)
  );

  // Redirect beats stall; a stall freezes PC and IF/ID together.
  always_comb begin
    state_d  = FS_RUN;
    pc_d     = pc_q + 32'd4;
    pc_out_d = pc_q + 32'd4;
    inst_d   = imem_data;
    valid_d  = 1'b1;
    if (branch_taken) begin
      state_d  = FS_FLUSH;
      pc_d     = branch_address & ~32'h3;
      pc_out_d = 32'h0;
      inst_d   = NOP_INSTR;
      valid_d  = 1'b0;
    end else if (freeze) begin
      state_d  = FS_STALL;
      pc_d     = pc_q;
      pc_out_d = pc_out_q;
      inst_d   = inst_q;
      valid_d  = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FS_RUN;
      pc_q     <= RESET_PC;
      pc_out_q <= 32'h0;
      inst_q   <= NOP_INSTR;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
    end
  end

  assign pc_out          = pc_out_q;
  assign instruction_out = inst_q;
  assign valid_out       = valid_q;
  assign fetch_state     = state_q;

`ifdef FETCH_STALL_COUNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (freeze && !branch_taken && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then random traffic
// compared each cycle against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam int MEM_DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        valid_out;
  logic [1:0]  fetch_state;
`ifdef FETCH_STALL_COUNT_EN
  logic [31:0] stall_count;
`endif

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC      (32'h0000_0000),
    .INST_MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .pc_out         (pc_out),
    .instruction_out(instruction_out),
    .valid_out      (valid_out),
    .fetch_state    (fetch_state)
`ifdef FETCH_STALL_COUNT_EN
    ,
    .stall_count    (stall_count)
`endif
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_pc_out;
  logic [31:0] m_inst;
  logic        m_valid;
  logic [1:0]  m_state;
  logic [31:0] m_cnt;

  function automatic logic [31:0] ref_mem(input logic [31:0] widx);
    if (widx >= MEM_DEPTH) return 32'h0;
    return 32'hA500_5A00 | (widx << 16) | (32'd255 - widx);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic f, input logic b, input logic [31:0] a);
    if (r) begin
      m_pc = 32'h0; m_pc_out = 32'h0; m_inst = 32'h0; m_valid = 1'b0; m_state = 2'd0; m_cnt = 32'h0;
    end else if (b) begin
      m_pc = {a[31:2], 2'b00}; m_pc_out = 32'h0; m_inst = 32'h0; m_valid = 1'b0; m_state = 2'd2;
    end else if (f) begin
      m_state = 2'd1;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end else begin
      m_pc_out = m_pc + 4;
      m_inst   = ref_mem(m_pc / 4);
      m_valid  = 1'b1;
      m_pc     = m_pc + 4;
      m_state  = 2'd0;
    end
  endtask

  task automatic step(input logic r, input logic f, input logic b, input logic [31:0] a);
    rst = r; freeze = f; branch_taken = b; branch_address = a;
    @(posedge clk);
    model_edge(r, f, b, a);
    #1;
    check_eq("pc_out", pc_out, m_pc_out);
    check_eq("instruction_out", instruction_out, m_inst);
    check_eq("valid_out", {31'b0, valid_out}, {31'b0, m_valid});
    check_eq("fetch_state", {30'b0, fetch_state}, {30'b0, m_state});
`ifdef FETCH_STALL_COUNT_EN
    check_eq("stall_count", stall_count, m_cnt);
`endif
  endtask

  logic [31:0] addr;
  int unsigned roll;

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_address = 32'h0;
    m_pc = 32'h0; m_pc_out = 32'h0; m_inst = 32'h0; m_valid = 1'b0; m_state = 2'd0; m_cnt = 32'h0;

    // Reset held two cycles, then sequential fetch
    step(1, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    check_eq("first_fetch_pc", pc_out, 32'h4);
    check_eq("first_fetch_inst", instruction_out, 32'hA500_5AFF);
    step(0, 0, 0, 32'h0);

    // Stall at PC=8 for three cycles
    step(0, 1, 0, 32'h0);
    step(0, 1, 0, 32'h0);
    step(0, 1, 0, 32'h0);
    check_eq("stall_hold_pc", pc_out, 32'h8);
    step(0, 0, 0, 32'h0);
    check_eq("stall_release_pc", pc_out, 32'hC);

    // Branch to 0x40
    step(0, 0, 1, 32'h40);
    step(0, 0, 0, 32'h0);
    check_eq("branch_target_pc", pc_out, 32'h44);

    // Branch and freeze together, misaligned target
    step(0, 1, 1, 32'h23);
    step(0, 0, 0, 32'h0);
    check_eq("priority_pc", pc_out, 32'h24);

    // Out-of-range fetch and PC wrap
    step(0, 0, 1, 32'h100);
    step(0, 0, 0, 32'h0);
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 32'h0);
    check_eq("wrap_pc", pc_out, 32'h0);
    step(0, 0, 0, 32'h0);

    // Reset while stalling
    step(0, 1, 0, 32'h0);
    step(1, 1, 0, 32'h0);
    step(0, 0, 0, 32'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      roll = $urandom_range(0, 99);
      case ($urandom_range(0, 3))
        0:       addr = 32'hFFFF_FFFC;
        1:       addr = $urandom;
        default: addr = $urandom_range(0, 32'h13F);
      endcase
      step(roll < 2, $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 10, addr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
